mvm_mac_lanes: RTL and testbench
================================

# mvm_mac_lanes

Parametrised L-lane matrix–vector multiply-accumulate engine, successor to the single-lane `mac_nnbit_1cc`. Each accepted beat carries one element of the shared vector E (broadcast to all lanes) and one element from each of L matrix rows G. After K beats the block delivers L dot products at once through a valid/ready output register. It adds runtime signed/unsigned mode, an exact-width accumulator, a synchronous partial-sum clear, backpressure, and back-to-back vectors with no bubbles. It sits between the garbled-input streaming front end and the result collector in the vdp benchmarks.

## Interface
- N, 8, operand bit-width.
- K, 3, vector dimension (beats per dot product); K ≥ 2.
- L, 3, number of lanes (matrix rows processed in parallel).
- ACC_W (localparam), 2*N+$clog2(K), per-lane accumulator/result width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low. It is sampled on the rising edge of clk, and state resets while rst==0.
- clear  in  1  synchronous abort; discards any partial dot product.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- g_input  in  L*N  lane i operand at [i*N +: N].
- e_input  in  N  vector element, shared by all lanes.
- out_valid  out  1  o holds a completed result.
- out_ready  in  1  consumer accepts o.
- o  out  L*ACC_W  lane i result at [i*ACC_W +: ACC_W].

## Operation
- Beat acceptance: a beat is accepted when in_valid && in_ready at a rising edge.
- in_ready = rst && !clear && !stall, where stall = out_valid && !out_ready.
- Stall: while stall is high, no pipeline stage advances. This covers the element counter, product register and accumulator.
- Element counter cnt runs 0..K-1. It increments on each accepted beat and wraps from K-1 to 0. The beat taken at cnt==K-1 is tagged last.
- Stage 1 (product register), per lane, on an accepted beat:
  - p[i] = ext(g[i]) * ext(e), with operands extended to N+1 bits.
  - ext sign-extends when signed_mode=1 and zero-extends when signed_mode=0.
  - The product is kept at 2N bits, then sign- or zero-extended to ACC_W.
  - Stage 1 also registers p_valid, the p_last tag and the mode.
- Stage 2 (accumulate), when p_valid is set and there is no stall:
  - Not last: acc[i] <= acc[i] + p[i].
  - Last: o[i] <= acc[i] + p[i], acc[i] <= 0, out_valid <= 1.
  - The next vector's first product therefore accumulates from zero in the following cycle, with no bubble.
- Output retirement: out_valid && out_ready at an edge retires the result. out_valid drops unless a new last product completes at the same edge; in that case o reloads and out_valid stays 1.
- Width rule: ACC_W is exact in both modes, so no overflow is possible.
  - Signed: K·2^(2N-2) fits in signed ACC_W.
  - Unsigned: K·(2^N-1)^2 fits in unsigned ACC_W.
  - The result is interpreted per the mode that was registered with the beats.
- signed_mode may change only at a vector boundary (cnt==0). A change mid-vector gives undefined results for that vector.
- clear (takes effect at an edge with rst==1):
  - cnt <= 0, acc <= 0, p_valid <= 0.
  - o and out_valid are untouched, so a finished result survives a clear.
  - in_ready is low during clear, so a beat presented at the same edge is not accepted.

## Timing
- Reset (rst==0 at an edge): o=0, out_valid=0, cnt=0, acc=0, p_valid=0.
- in_ready is 0 while rst==0 and rises combinationally when rst==1.
- Latency: the last beat accepted at edge c gives out_valid=1 and o valid after edge c+1 (2 cycles).
- Throughput: with out_ready held at 1, one L-lane result every K cycles.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and all internal state holds. There is no loss or duplication, and o stays stable.
- Reset mid-vector: all partial state and any pending result are discarded. The first beat after reset is element 0.
- Simultaneous clear and out_ready: the retirement completes and the clear applies.

## Test plan
- Reset behaviour: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, o=0 throughout.
- Signed, L=3, K=3, N=8:
  - Stimulus: rows G={29,74,-39}, {67,-71,56}, {75,-45,34} and E={-38,-91,47}, streamed on back-to-back beats.
  - Response: 2 cycles after the 3rd beat, out_valid=1 with lanes -9669, 6547, 2843 (18-bit; lane0=0x3DA3B).
- Unsigned corner: signed_mode=0, all operands 255 -> every lane 195075.
- Signed corner: all operands -128 -> every lane 49152. All operands -128 except E=127 -> every lane -48768.
- Backpressure and back-to-back:
  - Stimulus: 4 vectors streamed continuously, with out_ready=0 for 5 cycles while the 1st result is pending.
  - Response: in_ready=0 during the stall, and 4 correct results in order with no duplicates.
  - Repeat with out_ready=1: out_valid pulses every 3 cycles.
- Clear mid-vector: pulse clear after 2 beats, then send a full vector -> the result equals that vector's dot product only. A pending o from before the clear is preserved.

Source files
------------

// File: rtl/mvm_mac_lanes.sv
// rtl/mvm_mac_lanes.sv - L-lane matrix-vector multiply-accumulate engine with valid/ready output
//
// Purpose:
//   Each accepted beat carries one element of the shared vector E and one element of
//   each of L matrix rows G. After K beats the block presents L dot products at once
//   in an output register that the consumer drains with out_valid/out_ready.
//   Two stages: a product register (stage 1) and a per-lane accumulator (stage 2).
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous, active-low reset
//   clear        synchronous abort of the partial dot product (o/out_valid kept)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   in_valid     input beat valid
//   in_ready     block can accept a beat
//   g_input      lane i operand at [i*N +: N]
//   e_input      vector element shared by all lanes
//   out_valid    o holds a completed result
//   out_ready    consumer accepts o
//   o            lane i result at [i*ACC_W +: ACC_W]

module mvm_mac_lanes #(
   parameter int N = 8,
   parameter int K = 3,
   parameter int L = 3,
   localparam int ACC_W = 2*N + $clog2(K)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               signed_mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [L*N-1:0]     g_input,
   input  logic [N-1:0]       e_input,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [L*ACC_W-1:0] o
);

   localparam int CW  = $clog2(K);
   localparam int EXT = ACC_W - 2*N;

   logic             stall;
   logic             accept;
   logic             last_beat;
   logic [CW-1:0]    cnt;

   logic             p_valid;
   logic             p_last;
   logic             p_mode;
   logic [2*N-1:0]   p     [L];
   logic [ACC_W-1:0] acc   [L];

   logic [2*N-1:0]   e_ext;
   logic [2*N-1:0]   g_ext [L];
   logic [2*N-1:0]   prod  [L];
   logic [ACC_W-1:0] p_ext [L];
   logic [ACC_W-1:0] sum   [L];

   // A held result blocks the whole pipeline so nothing is lost or overwritten.
   assign stall     = out_valid && !out_ready;
   assign in_ready  = rst && !clear && !stall;
   assign accept    = in_valid && in_ready;
   assign last_beat = (cnt == CW'(K-1));

   // Operands are widened to 2N bits; the low 2N bits of the product are exact
   // for both N+1-bit signed and unsigned interpretations.
   assign e_ext = signed_mode ? {{N{e_input[N-1]}}, e_input} : {{N{1'b0}}, e_input};

   always_comb begin
      for (int i = 0; i < L; i++) begin
         g_ext[i] = signed_mode ? {{N{g_input[i*N+N-1]}}, g_input[i*N +: N]}
                                : {{N{1'b0}}, g_input[i*N +: N]};
         prod[i]  = g_ext[i] * e_ext;
         // Extension to the accumulator width follows the mode registered with the beat.
         p_ext[i] = p_mode ? {{EXT{p[i][2*N-1]}}, p[i]} : {{EXT{1'b0}}, p[i]};
         sum[i]   = acc[i] + p_ext[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt       <= '0;
         p_valid   <= 1'b0;
         p_last    <= 1'b0;
         p_mode    <= 1'b0;
         out_valid <= 1'b0;
         o         <= '0;
         for (int i = 0; i < L; i++) begin
            p[i]   <= '0;
            acc[i] <= '0;
         end
      end else begin
         // Retirement; a completion later in this block overrides it to keep out_valid high.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (clear) begin
            // Drop the partial sum and any in-flight product; a finished o survives.
            cnt     <= '0;
            p_valid <= 1'b0;
            for (int i = 0; i < L; i++) begin
               acc[i] <= '0;
            end
         end else if (!stall) begin
            // Stage 1: product register
            p_valid <= accept;
            if (accept) begin
               cnt    <= last_beat ? '0 : cnt + CW'(1);
               p_last <= last_beat;
               p_mode <= signed_mode;
               for (int i = 0; i < L; i++) begin
                  p[i] <= prod[i];
               end
            end

            // Stage 2: accumulate; the last product bypasses acc straight into o
            // so the next vector starts from zero without a bubble.
            if (p_valid) begin
               if (p_last) begin
                  out_valid <= 1'b1;
                  for (int i = 0; i < L; i++) begin
                     o[i*ACC_W +: ACC_W] <= sum[i];
                     acc[i]              <= '0;
                  end
               end else begin
                  for (int i = 0; i < L; i++) begin
                     acc[i] <= sum[i];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mvm_mac_lanes.sv
// tb/tb_mvm_mac_lanes.sv - self-checking bench for mvm_mac_lanes against an arithmetic dot-product model

module tb_mvm_mac_lanes;

   localparam int N     = 8;
   localparam int K     = 3;
   localparam int L     = 3;
   localparam int ACC_W = 2*N + $clog2(K);
   localparam int MAXV  = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               clear = 1'b0;
   logic               signed_mode = 1'b0;
   logic               in_valid = 1'b0;
   logic               out_ready = 1'b0;
   logic               in_ready;
   logic               out_valid;
   logic [L*N-1:0]     g_input = '0;
   logic [N-1:0]       e_input = '0;
   logic [L*ACC_W-1:0] o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [N-1:0]       vg [MAXV][K][L];
   logic [N-1:0]       ve [MAXV][K];
   bit                 vmode [MAXV];
   logic [L*ACC_W-1:0] last_o;

   always #5 clk = ~clk;

   mvm_mac_lanes #(.N(N), .K(K), .L(L)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .signed_mode (signed_mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .g_input     (g_input),
      .e_input     (e_input),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .o           (o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer dot product per lane, reduced modulo 2^ACC_W.
   function automatic logic [L*ACC_W-1:0] model(input int v);
      logic [L*ACC_W-1:0] r;
      longint s, a, b;
      r = '0;
      for (int l = 0; l < L; l++) begin
         s = 0;
         for (int k = 0; k < K; k++) begin
            if (vmode[v]) begin
               a = longint'($signed(vg[v][k][l]));
               b = longint'($signed(ve[v][k]));
            end else begin
               a = longint'(vg[v][k][l]);
               b = longint'(ve[v][k]);
            end
            s += a * b;
         end
         r[l*ACC_W +: ACC_W] = s[ACC_W-1:0];
      end
      return r;
   endfunction

   task automatic fill_random(input int v);
      for (int k = 0; k < K; k++) begin
         for (int l = 0; l < L; l++) vg[v][k][l] = N'($urandom);
         ve[v][k] = N'($urandom);
      end
      vmode[v] = 1'($urandom_range(1));
   endtask

   task automatic fill_const(input int v, input bit mode, input logic [N-1:0] gv, input logic [N-1:0] ev);
      for (int k = 0; k < K; k++) begin
         for (int l = 0; l < L; l++) vg[v][k][l] = gv;
         ve[v][k] = ev;
      end
      vmode[v] = mode;
   endtask

   task automatic drive_beat(input int v, input int k);
      for (int l = 0; l < L; l++) g_input[l*N +: N] = vg[v][k][l];
      e_input     = ve[v][k];
      signed_mode = vmode[v];
   endtask

   // Streams vectors v0..v0+nvec-1, stalls the first result for stall_cycles, and
   // checks every retired result, latency, hold-during-stall and optionally the rate.
   task automatic run_stream(input int v0, input int nvec, input int stall_cycles,
                             input bit gaps, input bit check_rate);
      logic [L*ACC_W-1:0] exp_q [$];
      logic [L*ACC_W-1:0] held, e;
      int  beat = 0, got = 0, cyc = 0, stall_left = stall_cycles;
      int  last_hs = -1, last_acc = -1, first_valid = -1;
      bit  acc, stalling;
      held = '0;
      for (int v = 0; v < nvec; v++) exp_q.push_back(model(v0 + v));
      while (got < nvec && cyc < 1000) begin
         if (beat < nvec*K && (!gaps || $urandom_range(3) != 0)) begin
            in_valid = 1'b1;
            drive_beat(v0 + beat / K, beat % K);
         end else begin
            in_valid = 1'b0;
         end
         stalling  = out_valid && (stall_left > 0);
         out_ready = !stalling;
         if (stalling) begin
            if (stall_left == stall_cycles) held = o;
            stall_left--;
         end
         @(negedge clk);
         if (stalling) begin
            n_tests++;
            if (in_ready !== 1'b0 || o !== held) begin
               n_fail++;
               $display("FAIL stall_hold: in_ready=%b o=%h required in_ready=0 o=%h", in_ready, o, held);
            end
         end
         acc = in_valid && in_ready;
         if (acc && beat == K-1) last_acc = cyc;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            last_o = o;
            n_tests++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL result[%0d]: o=%h required %h", v0 + got, o, e);
            end
            if (check_rate && last_hs >= 0) begin
               n_tests++;
               if (cyc - last_hs != K) begin
                  n_fail++;
                  $display("FAIL rate: interval=%0d required %0d", cyc - last_hs, K);
               end
            end
            last_hs = cyc;
            got++;
         end
         tick();
         if (acc) beat++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_tests++;
      if (got != nvec) begin
         n_fail++;
         $display("FAIL stream_timeout: results=%0d required %0d", got, nvec);
      end
      n_tests++;
      if (first_valid - last_acc != 2) begin
         n_fail++;
         $display("FAIL latency: cycles=%0d required 2", first_valid - last_acc);
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL no_duplicate: out_valid=%b required 0", out_valid);
      end
      tick();
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      in_valid = 1'b1;
      fill_random(0);
      drive_beat(0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         n_tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0 || o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b o=%h required 0 0 0", in_ready, out_valid, o);
         end
      end
      tick();
      rst       = 1'b1;
      out_ready = 1'b1;
      // Two beats of a vector, then reset: the next vector must start at element 0.
      for (int k = 0; k < 2; k++) begin
         drive_beat(0, k);
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b0;
      tick();
      rst = 1'b1;
      fill_random(1);
      run_stream(1, 1, 0, 0, 0);
   endtask

   task automatic test_signed_directed();
      int gt [L][K] = '{'{29, 74, -39}, '{67, -71, 56}, '{75, -45, 34}};
      int et [K]    = '{-38, -91, 47};
      for (int k = 0; k < K; k++) begin
         for (int l = 0; l < L; l++) vg[0][k][l] = N'(gt[l][k]);
         ve[0][k] = N'(et[k]);
      end
      vmode[0] = 1'b1;
      run_stream(0, 1, 0, 0, 0);
      n_tests++;
      if (last_o !== {18'd2843, 18'd6547, 18'h3DA3B}) begin
         n_fail++;
         $display("FAIL signed_directed: o=%h required %h", last_o, {18'd2843, 18'd6547, 18'h3DA3B});
      end
   endtask

   task automatic test_corners();
      fill_const(0, 1'b0, 8'd255, 8'd255);
      run_stream(0, 1, 0, 0, 0);
      n_tests++;
      if (last_o !== {3{18'd195075}}) begin
         n_fail++;
         $display("FAIL unsigned_corner: o=%h required %h", last_o, {3{18'd195075}});
      end
      fill_const(0, 1'b1, 8'h80, 8'h80);
      run_stream(0, 1, 0, 0, 0);
      n_tests++;
      if (last_o !== {3{18'd49152}}) begin
         n_fail++;
         $display("FAIL signed_corner_min: o=%h required %h", last_o, {3{18'd49152}});
      end
      fill_const(0, 1'b1, 8'h80, 8'd127);
      run_stream(0, 1, 0, 0, 0);
      n_tests++;
      if (last_o !== {3{18'd213376}}) begin
         n_fail++;
         $display("FAIL signed_corner_mixed: o=%h required %h", last_o, {3{18'd213376}});
      end
   endtask

   task automatic test_backpressure();
      for (int v = 0; v < 4; v++) fill_random(v);
      run_stream(0, 4, 5, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int v = 0; v < 4; v++) fill_random(v);
      run_stream(0, 4, 0, 0, 1);
   endtask

   task automatic test_clear();
      for (int v = 0; v < 3; v++) fill_random(v);
      out_ready = 1'b0;
      for (int k = 0; k < K; k++) begin
         in_valid = 1'b1;
         drive_beat(0, k);
         tick();
      end
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || o !== model(0)) begin
         n_fail++;
         $display("FAIL clear_pending: out_valid=%b o=%h required 1 %h", out_valid, o, model(0));
      end
      tick();
      clear    = 1'b1;
      in_valid = 1'b1;
      drive_beat(1, 0);
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_in_ready: in_ready=%b required 0", in_ready);
      end
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || o !== model(0)) begin
         n_fail++;
         $display("FAIL clear_preserve: out_valid=%b o=%h required 1 %h", out_valid, o, model(0));
      end
      tick();
      clear     = 1'b1;
      out_ready = 1'b1;
      tick();
      clear = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || o !== model(0)) begin
         n_fail++;
         $display("FAIL clear_with_retire: out_valid=%b o=%h required 0 %h", out_valid, o, model(0));
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         drive_beat(1, k);
         tick();
      end
      clear = 1'b1;
      drive_beat(1, 2);
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      run_stream(2, 1, 0, 0, 0);
   endtask

   task automatic test_random();
      int nv;
      for (int r = 0; r < 4; r++) begin
         nv = $urandom_range(6, 2);
         for (int v = 0; v < nv; v++) fill_random(v);
         run_stream(0, nv, $urandom_range(4), 1'b1, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_signed_directed();
      test_corners();
      test_backpressure();
      test_back_to_back();
      test_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
